// File: rtl/aes_pkg.sv
// AES helpers shared by the key expander and the round datapath:
// S-box table, xtime, Rcon seed and key-length derived constants.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    DONE
  } state_t;

  localparam logic [7:0] RCON_INIT = 8'h01;

  // Row-major, entry 0x00 in the top byte
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(
    input logic [7:0] x
  );
    return SBOX_TABLE[8*(255-int'(x)) +: 8];
  endfunction

  function automatic logic [7:0] xtime(
    input logic [7:0] x
  );
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic int nk_of(input int kb);
    return kb / 32;
  endfunction

  function automatic int nr_of(input int kb);
    return kb / 32 + 6;
  endfunction

  function automatic int nw_of(input int kb);
    return 4 * (kb / 32 + 7);
  endfunction

endpackage

// File: rtl/aes_sub_word.sv
// Combinational AES SubWord: four parallel S-box lookups.
// Shared between the key expander and the round datapath.
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [31:0] word,
  output logic [31:0] subbed
);

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    assign subbed[8*b +: 8] = sbox(word[8*b +: 8]);
  end

endmodule

// File: rtl/aes_key_expander.sv
// Sequential AES-128/192/256 key expansion, one schedule word per
// clock, with a registered forward/reverse round-key read port.
module aes_key_expander
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [KEY_BITS-1:0] inKey,
  output logic                busy,
  output logic                keyValid,
  input  logic [3:0]          rdRound,
  input  logic                rdReverse,
  output logic [127:0]        rdKey
);

  if (KEY_BITS != 128 && KEY_BITS != 192 &&
      KEY_BITS != 256) begin : g_bad_key
    $error("KEY_BITS must be 128, 192 or 256");
  end

  localparam int NK = nk_of(KEY_BITS);
  localparam int NR = nr_of(KEY_BITS);
  localparam int NW = nw_of(KEY_BITS);

  localparam logic [5:0] NK6     = 6'(NK);
  localparam logic [5:0] NW_LAST = 6'(NW - 1);
  localparam logic [2:0] P_LAST  = 3'(NK - 1);
  localparam logic [3:0] NR4     = 4'(NR);

  state_t state_q, state_d;

  logic [31:0] words_q [NW];
  logic [5:0]  i_q;
  logic [2:0]  p_q;
  logic [7:0]  rcon_q;

  logic        load;
  logic        step;
  logic [31:0] temp;
  logic [31:0] sub_in;
  logic [31:0] sub_out;
  logic [31:0] temp_n;
  logic [31:0] new_word;
  logic [3:0]  ra;
  logic [5:0]  base;

  assign busy     = (state_q == EXPAND);
  assign keyValid = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          load    = 1'b1;
          state_d = EXPAND;
        end
      end
      EXPAND: begin
        step = 1'b1;
        if (i_q == NW_LAST) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // p tracks i mod Nk without a divider
  assign temp   = words_q[i_q - 6'd1];
  assign sub_in = (p_q == 3'd0) ? {temp[23:0], temp[31:24]} : temp;

  aes_sub_word u_sub_word (
    .word   (sub_in),
    .subbed (sub_out)
  );

  always_comb begin
    temp_n = temp;
    unique case (1'b1)
      p_q == 3'd0:
        temp_n = sub_out ^ {rcon_q, 24'h0};
      (NK == 8) && (p_q == 3'd4):
        temp_n = sub_out;
      default: ;
    endcase
  end

  assign new_word = words_q[i_q - NK6] ^ temp_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      i_q     <= '0;
      p_q     <= '0;
      rcon_q  <= RCON_INIT;
    end else begin
      state_q <= state_d;
      if (load) begin
        i_q    <= NK6;
        p_q    <= '0;
        rcon_q <= RCON_INIT;
      end else if (step) begin
        i_q <= i_q + 6'd1;
        p_q <= (p_q == P_LAST) ? 3'd0 : p_q + 3'd1;
        if (p_q == 3'd0) rcon_q <= xtime(rcon_q);
      end
    end
  end

  // Schedule buffer keeps its contents across reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (load) begin
        for (int k = 0; k < NK; k++) begin
          words_q[k] <= inKey[KEY_BITS-1-32*k -: 32];
        end
      end else if (step) begin
        words_q[i_q] <= new_word;
      end
    end
  end

  assign ra   = rdReverse ? NR4 - rdRound : rdRound;
  assign base = {ra, 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      rdKey <= '0;
    end else if (rdRound > NR4) begin
      rdKey <= '0;
    end else begin
      rdKey <= {words_q[base],
                words_q[base + 6'd1],
                words_q[base + 6'd2],
                words_q[base + 6'd3]};
    end
  end

endmodule

// File: tb/tb_aes_key_expander.sv
// Bench for aes_key_expander: 128/192/256 instances share stimulus and
// are checked every cycle against a GF(2^8)-based reference schedule.
module tb_aes_key_expander;

  logic         clk;
  logic         rst;
  logic         start;
  logic [255:0] key;
  logic [3:0]   rd_round;
  logic         rd_reverse;
  logic [2:0]   busy_v;
  logic [2:0]   valid_v;
  logic [127:0] rd_key_v [3];

  int checks = 0;
  int errors = 0;

  aes_key_expander #(.KEY_BITS(128)) u_dut128 (
    .clk(clk), .rst(rst), .start(start),
    .inKey(key[255:128]),
    .busy(busy_v[0]), .keyValid(valid_v[0]),
    .rdRound(rd_round), .rdReverse(rd_reverse),
    .rdKey(rd_key_v[0])
  );

  aes_key_expander #(.KEY_BITS(192)) u_dut192 (
    .clk(clk), .rst(rst), .start(start),
    .inKey(key[255:64]),
    .busy(busy_v[1]), .keyValid(valid_v[1]),
    .rdRound(rd_round), .rdReverse(rd_reverse),
    .rdKey(rd_key_v[1])
  );

  aes_key_expander #(.KEY_BITS(256)) u_dut256 (
    .clk(clk), .rst(rst), .start(start),
    .inKey(key),
    .busy(busy_v[2]), .keyValid(valid_v[2]),
    .rdRound(rd_round), .rdReverse(rd_reverse),
    .rdKey(rd_key_v[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference S-box from GF(2^8) inverse plus affine map
  logic [7:0] sbox_ref [256];

  function automatic logic [7:0] gmul(
    input logic [7:0] a_in, input logic [7:0] b
  );
    logic [7:0] a;
    logic [7:0] p;
    a = a_in;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(
    input logic [7:0] b, input int s
  );
    return (b << s) | (b >> (8 - s));
  endfunction

  initial begin
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_ref[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2)
                  ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  end

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox_ref[w[31:24]], sbox_ref[w[23:16]],
            sbox_ref[w[15:8]], sbox_ref[w[7:0]]};
  endfunction

  logic [31:0]  m_sched [3][60];
  bit           m_busy [3];
  bit           m_valid [3];
  int           m_cnt [3];
  logic [127:0] m_rd [3];
  bit           m_rd_chk [3];
  bit           armed = 0;

  function automatic void expand(
    input int n, input logic [255:0] k
  );
    int nk;
    int nw;
    logic [31:0] t;
    logic [7:0] rc;
    nk = 4 + 2 * n;
    nw = 4 * (nk + 7);
    for (int i = 0; i < nw; i++) begin
      if (i < nk) begin
        m_sched[n][i] = k[255-32*i -: 32];
      end else begin
        t = m_sched[n][i-1];
        if (i % nk == 0) begin
          rc = 8'h01;
          for (int j = 1; j < i / nk; j++) rc = gmul(rc, 8'h02);
          t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        end else if (nk > 6 && i % nk == 4) begin
          t = subw(t);
        end
        m_sched[n][i] = m_sched[n][i-nk] ^ t;
      end
    end
  endfunction

  always @(posedge clk) begin
    for (int n = 0; n < 3; n++) begin
      int nk;
      int nr;
      int ra;
      nk = 4 + 2 * n;
      nr = nk + 6;
      if (rst) begin
        m_busy[n]   = 0;
        m_valid[n]  = 0;
        m_cnt[n]    = 0;
        m_rd[n]     = '0;
        m_rd_chk[n] = 1;
      end else begin
        ra = rd_reverse ? nr - int'(rd_round) : int'(rd_round);
        if (int'(rd_round) > nr) begin
          m_rd[n]     = '0;
          m_rd_chk[n] = 1;
        end else if (m_valid[n]) begin
          m_rd[n] = {m_sched[n][4*ra], m_sched[n][4*ra+1],
                     m_sched[n][4*ra+2], m_sched[n][4*ra+3]};
          m_rd_chk[n] = 1;
        end else begin
          m_rd_chk[n] = 0;
        end
        if (m_busy[n]) begin
          m_cnt[n]--;
          if (m_cnt[n] == 0) begin
            m_busy[n]  = 0;
            m_valid[n] = 1;
          end
        end else if (start) begin
          expand(n, key);
          m_busy[n]  = 1;
          m_valid[n] = 0;
          m_cnt[n]   = 4 * (nr + 1) - nk;
        end
      end
    end
    armed = 1;
  end

  function automatic void check(
    input string nm,
    input logic [127:0] act,
    input logic [127:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (armed) begin
      for (int n = 0; n < 3; n++) begin
        check($sformatf("busy%0d", n), 128'(busy_v[n]),
              128'(m_busy[n]));
        check($sformatf("keyValid%0d", n), 128'(valid_v[n]),
              128'(m_valid[n]));
        if (m_rd_chk[n])
          check($sformatf("rdKey%0d", n), rd_key_v[n], m_rd[n]);
      end
    end
  end

  int lat [3];

  function automatic logic [255:0] rand256();
    return {$urandom, $urandom, $urandom, $urandom,
            $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic start_key(input logic [255:0] k);
    key   = k;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int c;
    bit seen [3];
    c = 1;
    seen = '{0, 0, 0};
    lat  = '{0, 0, 0};
    while (c < 100) begin
      for (int n = 0; n < 3; n++)
        if (!seen[n] && valid_v[n] === 1'b1) begin
          seen[n] = 1;
          lat[n]  = c;
        end
      if (seen[0] && seen[1] && seen[2]) break;
      rd_round   = 4'($urandom_range(0, 15));
      rd_reverse = 1'($urandom);
      @(negedge clk);
      c++;
    end
    if (!(seen[0] && seen[1] && seen[2])) begin
      checks++;
      errors++;
      $display("FAIL wait_done: got timeout expected keyValid");
    end
  endtask

  task automatic rd_set(input int r, input bit rev);
    rd_round   = 4'(r);
    rd_reverse = rev;
    @(negedge clk);
  endtask

  task automatic sweep(input int cnt);
    for (int j = 0; j < cnt; j++)
      rd_set($urandom_range(0, 15), 1'($urandom));
  endtask

  localparam logic [255:0] K128 =
    {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 =
    {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  initial begin
    logic [255:0] ka;
    rst        = 1'b1;
    start      = 1'b0;
    key        = '0;
    rd_round   = 4'd0;
    rd_reverse = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", 128'(busy_v), 128'(3'b000));
    check("reset_valid", 128'(valid_v), 128'(3'b000));
    check("reset_rdkey", rd_key_v[0], 128'h0);
    rst = 1'b0;
    @(negedge clk);

    start_key(K128);
    wait_done();
    check("lat128", 128'(lat[0]), 128'(41));
    check("lat192", 128'(lat[1]), 128'(47));
    check("lat256", 128'(lat[2]), 128'(53));
    rd_set(1, 0);
    check("k128_r1", rd_key_v[0],
          128'ha0fafe1788542cb123a339392a6c7605);
    rd_set(10, 0);
    check("k128_r10", rd_key_v[0],
          128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    rd_set(0, 1);
    check("k128_rev0", rd_key_v[0],
          128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    rd_set(10, 1);
    check("k128_rev10", rd_key_v[0],
          128'h2b7e151628aed2a6abf7158809cf4f3c);
    rd_set(11, 1);
    check("k128_rev11", rd_key_v[0], 128'h0);

    start_key(K192);
    check("done_restart_drop", 128'(valid_v), 128'(3'b000));
    wait_done();
    rd_set(12, 0);
    check("k192_r12", rd_key_v[1],
          128'he98ba06f448c773c8ecc720401002202);
    rd_set(13, 0);
    check("k192_r13", rd_key_v[1], 128'h0);

    start_key(K256);
    wait_done();
    rd_set(14, 0);
    check("k256_r14", rd_key_v[2],
          128'hfe4890d1e6188d0b046df344706c631e);
    rd_set(0, 1);
    check("k256_rev0", rd_key_v[2],
          128'hfe4890d1e6188d0b046df344706c631e);

    start_key(rand256());
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", 128'(busy_v), 128'(3'b000));
    check("midrst_valid", 128'(valid_v), 128'(3'b000));
    check("midrst_rd0", rd_key_v[0], 128'h0);
    check("midrst_rd2", rd_key_v[2], 128'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    start_key(rand256());
    wait_done();
    sweep(16);

    ka = rand256();
    start_key(ka);
    repeat (5) @(negedge clk);
    start_key(rand256());
    wait_done();
    rd_set(0, 0);
    check("ignored_start_r0", rd_key_v[0], ka[255:128]);
    check("ignored_start_r0_256", rd_key_v[2], ka[255:128]);
    sweep(16);

    for (int it = 0; it < 15; it++) begin
      start_key(rand256());
      wait_done();
      sweep(20);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
